xgmii_tx_encoder: RTL and testbench

- Final TX MAC stage, directly downstream of the preamble-insertion stage.
- Consumes 64-bit AXI-Stream frames whose first beat is the 8-byte preamble/SFD, and drives the 64-bit single-rate XGMII transmit bus (lane 0 = bits [7:0]).
- Inserts /S/, /T/, /E/ and /I/ control characters and enforces the minimum inter-frame gap.
- XGMII cannot stall: an upstream underrun mid-frame aborts the frame on the wire.

---
 rtl/xgmii_tx_encoder_if.sv | 24 ++
 rtl/xgmii_tx_encoder.sv | 142 ++++++++++++++
 tb/tb_xgmii_tx_encoder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xgmii_tx_encoder_if.sv
// AXI-Stream ingress and XGMII egress bundle of the TX encoder.
// The slave modport is the encoder's view; the master modport is the upstream/bus-tap side.
interface xgmii_tx_encoder_if;
    logic [63:0] saxis_tdata;
    logic        saxis_tvalid;
    logic        saxis_tready;
    logic [7:0]  saxis_tkeep;
    logic        saxis_tlast;
    logic        saxis_tuser;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        tx_underrun;
    logic        tx_frame_done;

    modport master (
        output saxis_tdata, saxis_tvalid, saxis_tkeep, saxis_tlast, saxis_tuser,
        input  saxis_tready, xgmii_txd, xgmii_txc, tx_underrun, tx_frame_done
    );

    modport slave (
        input  saxis_tdata, saxis_tvalid, saxis_tkeep, saxis_tlast, saxis_tuser,
        output saxis_tready, xgmii_txd, xgmii_txc, tx_underrun, tx_frame_done
    );
endinterface

// File: rtl/xgmii_tx_encoder.sv
// Final TX MAC stage: frames AXI-Stream beats onto the 64-bit XGMII bus with
// /S/ /T/ /E/ /I/ insertion, minimum inter-frame gap and underrun abort.
module xgmii_tx_encoder #(
    parameter int unsigned IFG_BYTES = 12
) (
    input  logic              clock,
    input  logic              aresetn,
    xgmii_tx_encoder_if.slave bus
);
    localparam logic [7:0]  CH_S      = 8'hFB;
    localparam logic [7:0]  CH_T      = 8'hFD;
    localparam logic [7:0]  CH_E      = 8'hFE;
    localparam logic [63:0] IDLE_WORD = {8{8'h07}};
    localparam logic [63:0] ERR_WORD  = {8{8'hFE}};
    localparam logic [63:0] TERM_WORD = {{7{8'h07}}, CH_T};

    typedef enum logic [2:0] {IDLE, DATA, TERM, ERR_TERM, ABORT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ifg_q, ifg_d;
    logic        last_seen_q, last_seen_d;
    logic [63:0] txd_q, txd_d;
    logic [7:0]  txc_q, txc_d;
    logic        underrun_q, underrun_d;
    logic        done_q, done_d;
    logic        tready;
    logic        accept;
    int unsigned nbytes;

    // Full idle words still owed after a /T/ whose word carries term_bytes of gap.
    function automatic logic [3:0] gap_words(input int unsigned term_bytes);
        int unsigned w;
        w = 0;
        if (IFG_BYTES > term_bytes) w = (IFG_BYTES - term_bytes + 7) / 8;
        return 4'(w);
    endfunction

    always_comb begin
        nbytes = 0;
        for (int unsigned i = 0; i < 8; i++)
            if (bus.saxis_tkeep[i]) nbytes = nbytes + 1;
    end

    always_comb begin
        tready = 1'b0;
        case (state_q)
            IDLE:        tready = (ifg_q == '0);
            DATA, ABORT: tready = 1'b1;
            default:     tready = 1'b0;
        endcase
    end

    assign accept           = bus.saxis_tvalid & tready;
    assign bus.saxis_tready = tready & aresetn;

    always_comb begin
        state_d     = state_q;
        ifg_d       = (ifg_q != '0) ? ifg_q - 4'd1 : '0;
        last_seen_d = last_seen_q;
        txd_d       = IDLE_WORD;
        txc_d       = '1;
        underrun_d  = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    txd_d       = {bus.saxis_tdata[63:8], CH_S};
                    txc_d       = 8'h01;
                    last_seen_d = bus.saxis_tlast;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (!bus.saxis_tvalid) begin
                    txd_d      = ERR_WORD;
                    underrun_d = 1'b1;
                    state_d    = ERR_TERM;
                end else if (!bus.saxis_tlast) begin
                    txd_d = bus.saxis_tdata;
                    txc_d = '0;
                end else begin
                    // Lanes past /T/ keep the idle default.
                    for (int unsigned i = 0; i < 8; i++) begin
                        if (i < nbytes) begin
                            txd_d[8*i +: 8] = bus.saxis_tuser ? CH_E : bus.saxis_tdata[8*i +: 8];
                            txc_d[i]        = bus.saxis_tuser;
                        end else if (i == nbytes) begin
                            txd_d[8*i +: 8] = CH_T;
                        end
                    end
                    if (nbytes == 8) begin
                        state_d = TERM;
                    end else begin
                        done_d  = 1'b1;
                        ifg_d   = gap_words(8 - nbytes);
                        state_d = IDLE;
                    end
                end
            end
            TERM: begin
                txd_d   = TERM_WORD;
                done_d  = 1'b1;
                ifg_d   = gap_words(8);
                state_d = IDLE;
            end
            ERR_TERM: begin
                txd_d   = TERM_WORD;
                ifg_d   = gap_words(8);
                state_d = last_seen_q ? IDLE : ABORT;
            end
            ABORT: begin
                if (accept && bus.saxis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            ifg_q       <= '0;
            last_seen_q <= 1'b0;
            txd_q       <= IDLE_WORD;
            txc_q       <= '1;
            underrun_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ifg_q       <= ifg_d;
            last_seen_q <= last_seen_d;
            txd_q       <= txd_d;
            txc_q       <= txc_d;
            underrun_q  <= underrun_d;
            done_q      <= done_d;
        end
    end

    assign bus.xgmii_txd     = txd_q;
    assign bus.xgmii_txc     = txc_q;
    assign bus.tx_underrun   = underrun_q;
    assign bus.tx_frame_done = done_q;
endmodule

// File: tb/tb_xgmii_tx_encoder.sv
// Scoreboard bench for xgmii_tx_encoder: frames are expanded into the expected
// XGMII byte stream, and a monitor checks every word and every inter-frame gap.
module tb_xgmii_tx_encoder;
    localparam int          IFG    = 12;
    localparam logic [63:0] IDLE_W = 64'h0707070707070707;

    logic clock   = 1'b0;
    logic aresetn = 1'b0;

    xgmii_tx_encoder_if bus();

    xgmii_tx_encoder #(.IFG_BYTES(IFG)) dut (
        .clock   (clock),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        bit          done;
        bit          und;
        bit          first;
        bit          last;
        int          gap;
        bit          exact;
    } exp_t;

    exp_t        sb[$];
    int          n_checks   = 0;
    int          n_pass     = 0;
    logic [63:0] fb [0:7];
    int          next_gap   = 0;
    bit          next_exact = 1'b0;

    task automatic finish_bench();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    function automatic logic [7:0] keep_of(input int n);
        logic [8:0] t;
        t = (9'd1 << n) - 9'd1;
        return t[7:0];
    endfunction

    // Expand a frame into its on-wire (ctrl,byte) stream, then cut it into words.
    task automatic push_frame(input int nb, input int nlast, input bit tuser,
                              input int under_at, input bit exact_gap);
        logic [8:0] st[$];
        int tpos, nw, term;
        exp_t e;
        st.push_back({1'b1, 8'hFB});
        for (int i = 1; i < 8; i++) st.push_back({1'b0, fb[0][8*i +: 8]});
        if (under_at == 0) begin
            for (int b = 1; b < nb; b++) begin
                int cnt;
                cnt = (b == nb - 1) ? nlast : 8;
                for (int i = 0; i < cnt; i++) begin
                    if (b == nb - 1 && tuser) st.push_back({1'b1, 8'hFE});
                    else st.push_back({1'b0, fb[b][8*i +: 8]});
                end
            end
        end else begin
            for (int b = 1; b < under_at; b++)
                for (int i = 0; i < 8; i++) st.push_back({1'b0, fb[b][8*i +: 8]});
            repeat (8) st.push_back({1'b1, 8'hFE});
        end
        tpos = st.size() % 8;
        st.push_back({1'b1, 8'hFD});
        while (st.size() % 8 != 0) st.push_back({1'b1, 8'h07});
        nw = st.size() / 8;
        for (int w = 0; w < nw; w++) begin
            for (int i = 0; i < 8; i++) begin
                e.d[8*i +: 8] = st[8*w + i][7:0];
                e.c[i]        = st[8*w + i][8];
            end
            e.first = (w == 0);
            e.last  = (w == nw - 1);
            e.done  = e.last && (under_at == 0);
            e.und   = (under_at != 0) && (w == nw - 2);
            e.gap   = next_gap;
            e.exact = exact_gap && next_exact;
            sb.push_back(e);
        end
        term       = 8 - tpos;
        next_gap   = (IFG > term) ? (IFG - term + 7) / 8 : 0;
        next_exact = (under_at == 0);
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k,
                              input bit last, input bit user);
        int n;
        n = 0;
        bus.saxis_tdata  = d;
        bus.saxis_tkeep  = k;
        bus.saxis_tlast  = last;
        bus.saxis_tuser  = user;
        bus.saxis_tvalid = 1'b1;
        forever begin
            @(negedge clock);
            if (bus.saxis_tready) break;
            n++;
            if (n > 200) begin
                n_checks++;
                $display("FAIL beat_accept: tready low for %0d cycles, required 1", n);
                finish_bench();
            end
        end
        @(posedge clock);
        #1;
        bus.saxis_tvalid = 1'b0;
        bus.saxis_tlast  = 1'b0;
        bus.saxis_tuser  = 1'b0;
    endtask

    task automatic load_beats(input int nb);
        fb[0] = 64'hd555555555555555;
        for (int b = 1; b < nb; b++) fb[b] = {$urandom, $urandom};
    endtask

    task automatic send_frame(input int nb, input int nlast, input bit tuser,
                              input int under_at, input int delay);
        load_beats(nb);
        push_frame(nb, nlast, tuser, under_at, delay == 0);
        repeat (delay) begin
            @(posedge clock);
            #1;
        end
        for (int b = 0; b < nb; b++) begin
            if (under_at != 0 && b == under_at) begin
                @(posedge clock);
                #1;
            end
            drive_beat(fb[b], (b == nb - 1) ? keep_of(nlast) : 8'hFF,
                       b == nb - 1, tuser && (b == nb - 1));
        end
    endtask

    initial begin : monitor
        bit   in_frame;
        int   idle_cnt;
        exp_t e;
        in_frame = 1'b0;
        idle_cnt = 0;
        forever begin
            @(negedge clock);
            if (!aresetn) begin
                in_frame = 1'b0;
                idle_cnt = 0;
            end else if (!in_frame && bus.xgmii_txd == IDLE_W && bus.xgmii_txc == 8'hFF) begin
                idle_cnt++;
                chk("idle_pulses", {62'd0, bus.tx_frame_done, bus.tx_underrun}, 64'd0);
            end else if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got txd=%h txc=%h, required idle",
                         bus.xgmii_txd, bus.xgmii_txc);
            end else begin
                e = sb.pop_front();
                if (e.first) begin
                    if (e.exact) chk("gap_exact", 64'(idle_cnt), 64'(e.gap));
                    else chk("gap_min", {63'd0, idle_cnt >= e.gap}, 64'd1);
                end
                chk("txd", bus.xgmii_txd, e.d);
                chk("txc_pulses", {54'd0, bus.xgmii_txc, bus.tx_frame_done, bus.tx_underrun},
                    {54'd0, e.c, e.done, e.und});
                in_frame = !e.last;
                if (e.last) idle_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        n_checks++;
        $display("FAIL watchdog: bench still running at %0t, required completion", $time);
        finish_bench();
    end

    initial begin
        int nb, nl, ua, dl;
        bit tu;
        bus.saxis_tdata  = '0;
        bus.saxis_tkeep  = '0;
        bus.saxis_tlast  = 1'b0;
        bus.saxis_tuser  = 1'b0;
        bus.saxis_tvalid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_txd", bus.xgmii_txd, IDLE_W);
        chk("rst_txc", {56'd0, bus.xgmii_txc}, 64'hFF);
        chk("rst_tready", {63'd0, bus.saxis_tready}, 64'd0);
        chk("rst_pulses", {62'd0, bus.tx_frame_done, bus.tx_underrun}, 64'd0);
        aresetn = 1'b1;

        send_frame(3, 4, 1'b0, 0, 0);
        send_frame(3, 8, 1'b0, 0, 0);
        send_frame(2, 2, 1'b0, 0, 0);
        send_frame(4, 7, 1'b0, 0, 0);
        send_frame(2, 5, 1'b0, 0, 0);
        send_frame(3, 2, 1'b1, 0, 0);
        send_frame(3, 8, 1'b1, 0, 0);
        send_frame(5, 3, 1'b0, 2, 0);
        send_frame(3, 6, 1'b0, 0, 0);

        // Reset lands between edges after two beats of a three-beat frame.
        load_beats(3);
        push_frame(3, 4, 1'b0, 0, 1'b1);
        drive_beat(fb[0], 8'hFF, 1'b0, 1'b0);
        drive_beat(fb[1], 8'hFF, 1'b0, 1'b0);
        #2;
        aresetn = 1'b0;
        sb.delete();
        #1;
        chk("midrst_txd", bus.xgmii_txd, IDLE_W);
        chk("midrst_txc", {56'd0, bus.xgmii_txc}, 64'hFF);
        chk("midrst_tready", {63'd0, bus.saxis_tready}, 64'd0);
        @(posedge clock);
        #1;
        aresetn = 1'b1;
        #1;
        chk("postrst_tready", {63'd0, bus.saxis_tready}, 64'd1);
        next_gap   = 0;
        next_exact = 1'b0;
        send_frame(3, 1, 1'b0, 0, 0);

        for (int f = 0; f < 40; f++) begin
            nb = int'($urandom_range(7, 2));
            nl = int'($urandom_range(8, 1));
            tu = ($urandom_range(5, 0) == 0);
            ua = ($urandom_range(5, 0) == 0) ? int'($urandom_range(nb - 1, 1)) : 0;
            dl = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            send_frame(nb, nl, tu, ua, dl);
        end

        repeat (30) @(posedge clock);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        finish_bench();
    end
endmodule
